// File: rtl/bananachine_pkg.sv
// Shared types and encodings for the multicycle controller and its instruction decoder.
package bananachine_pkg;

    // Controller states; the numeric values are exported on state_dbg.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC   = 4'd3,
        MEM_RD = 4'd4,
        MEM_WR = 4'd5,
        BRANCH = 4'd6,
        NOP    = 4'd7
    } state_e;

    // Instruction classes produced by the decoder.
    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_LOAD,
        CLS_STOR,
        CLS_JCOND,
        CLS_JAL,
        CLS_BCOND
    } instr_class_e;

    // Primary opcodes (instruction bits [15:12]).
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;

    // Extended opcodes (instruction bits [7:4]) under OP_MEM.
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    // ALU function codes shared by R-type ext and I-type op fields.
    localparam logic [3:0] FN_ADD = 4'b0101;
    localparam logic [3:0] FN_SUB = 4'b1001;
    localparam logic [3:0] FN_CMP = 4'b1011;

    // pc_src encodings.
    localparam logic [1:0] PC_SRC_INC  = 2'b00;
    localparam logic [1:0] PC_SRC_DISP = 2'b01;
    localparam logic [1:0] PC_SRC_RTGT = 2'b10;

    // reg_write_src encodings.
    localparam logic [1:0] RWS_ALU = 2'b00;
    localparam logic [1:0] RWS_MEM = 2'b01;
    localparam logic [1:0] RWS_PC1 = 2'b10;

    localparam logic [5:0] ALU_PASS_B = 6'b111111;

    // ADD/SUB/CMP forms are the only ones that update the PSR flags.
    function automatic logic is_flag_op(input logic [3:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_CMP);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/decode bundle between the controller and the datapath/memory.
interface multicycle_controller_if #(
    parameter int ALU_CONT_W = 6
);
    import bananachine_pkg::*;

    logic                  run;
    logic [3:0]            op_code;
    logic [3:0]            ext_op_code;
    logic                  cond_true;
    logic                  instr_en;
    logic                  mem_addr_src;
    logic                  mem_we;
    logic                  pc_en;
    logic [1:0]            pc_src;
    logic                  reg_write;
    logic [1:0]            reg_write_src;
    logic                  alu_A_src;
    logic                  alu_B_src;
    logic [ALU_CONT_W-1:0] alu_cont;
    logic                  psr_en;
    logic [3:0]            state_dbg;

    // Controller side: consumes decode info, drives strobes.
    modport master (
        input  run, op_code, ext_op_code, cond_true,
        output instr_en, mem_addr_src, mem_we, pc_en, pc_src, reg_write,
               reg_write_src, alu_A_src, alu_B_src, alu_cont, psr_en, state_dbg
    );

    // Datapath side: supplies decode info, receives strobes.
    modport slave (
        output run, op_code, ext_op_code, cond_true,
        input  instr_en, mem_addr_src, mem_we, pc_en, pc_src, reg_write,
               reg_write_src, alu_A_src, alu_B_src, alu_cont, psr_en, state_dbg
    );

endinterface

// File: rtl/multicycle_controller_inst_decoder.sv
// Combinational instruction classifier plus ALU-control / flag-update decode.
module inst_decoder
    import bananachine_pkg::*;
#(
    parameter int EN_JAL = 1
) (
    input  logic [3:0]   op_code,
    input  logic [3:0]   ext_op_code,
    output instr_class_e cls,
    output logic [5:0]   alu_cont,
    output logic         alu_b_imm,
    output logic         psr_en,
    output logic         writes_reg
);

    // Classify the instruction and derive its ALU behaviour.
    always_comb begin
        cls        = CLS_NOP;
        alu_cont   = '0;
        alu_b_imm  = 1'b0;
        psr_en     = 1'b0;
        writes_reg = 1'b0;
        case (op_code)
            OP_RTYPE: begin
                cls        = CLS_RTYPE;
                alu_cont   = {2'b00, ext_op_code};
                psr_en     = is_flag_op(ext_op_code);
                writes_reg = (ext_op_code != FN_CMP);
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
                cls        = CLS_ITYPE;
                alu_b_imm  = 1'b1;
                alu_cont   = (op_code == OP_MOVI) ? ALU_PASS_B : {2'b01, op_code};
                psr_en     = is_flag_op(op_code);
                writes_reg = (op_code != OP_CMPI);
            end
            OP_MEM: begin
                case (ext_op_code)
                    EXT_LOAD:  cls = CLS_LOAD;
                    EXT_STOR:  cls = CLS_STOR;
                    EXT_JCOND: cls = CLS_JCOND;
                    EXT_JAL:   if (EN_JAL != 0) cls = CLS_JAL;
                    default:   cls = CLS_NOP;
                endcase
            end
            OP_BCOND: cls = CLS_BCOND;
            default:  cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM sequencing fetch/decode/execute for the datapath and memory.
module multicycle_controller
    import bananachine_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ALU_CONT_W  = 6,
    parameter int EN_JAL      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            wait_done;
    state_e          next_after;

    instr_class_e    dec_cls;
    logic [5:0]      dec_alu_cont;
    logic            dec_b_imm;
    logic            dec_psr_en;
    logic            dec_writes_reg;

    logic                  instr_en;
    logic                  mem_addr_src;
    logic                  mem_we;
    logic                  pc_en;
    logic [1:0]            pc_src;
    logic                  reg_write;
    logic [1:0]            reg_write_src;
    logic                  alu_a_src;
    logic                  alu_b_src;
    logic [ALU_CONT_W-1:0] alu_cont;
    logic                  psr_en;

    inst_decoder #(.EN_JAL(EN_JAL)) u_dec (
        .op_code     (bus.op_code),
        .ext_op_code (bus.ext_op_code),
        .cls         (dec_cls),
        .alu_cont    (dec_alu_cont),
        .alu_b_imm   (dec_b_imm),
        .psr_en      (dec_psr_en),
        .writes_reg  (dec_writes_reg)
    );

    // The final cycle of a memory access is the one where the counter reaches the latency.
    assign wait_done  = (cnt_q == CNT_LAST);
    assign next_after = bus.run ? FETCH : IDLE;

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and wait-counter update; counter clears on every state change and saturates.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (bus.run) state_d = FETCH;
            FETCH:  if (wait_done) state_d = DECODE;
            DECODE: begin
                case (dec_cls)
                    CLS_RTYPE, CLS_ITYPE:           state_d = EXEC;
                    CLS_LOAD:                       state_d = MEM_RD;
                    CLS_STOR:                       state_d = MEM_WR;
                    CLS_JCOND, CLS_JAL, CLS_BCOND:  state_d = BRANCH;
                    default:                        state_d = NOP;
                endcase
            end
            EXEC, MEM_WR, BRANCH, NOP: state_d = next_after;
            MEM_RD: if (wait_done) state_d = next_after;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            cnt_d = '0;
        else if (!wait_done)
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;
    end

    // Moore outputs from state plus current decode; everything is forced low during reset.
    always_comb begin
        instr_en      = 1'b0;
        mem_addr_src  = 1'b0;
        mem_we        = 1'b0;
        pc_en         = 1'b0;
        pc_src        = PC_SRC_INC;
        reg_write     = 1'b0;
        reg_write_src = RWS_ALU;
        alu_a_src     = 1'b0;
        alu_b_src     = 1'b0;
        alu_cont      = '0;
        psr_en        = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: instr_en = wait_done;
                EXEC: begin
                    alu_a_src = 1'b1;
                    alu_b_src = dec_b_imm;
                    alu_cont  = ALU_CONT_W'(dec_alu_cont);
                    reg_write = dec_writes_reg;
                    psr_en    = dec_psr_en;
                    pc_en     = 1'b1;
                end
                MEM_RD: begin
                    mem_addr_src  = 1'b1;
                    reg_write_src = RWS_MEM;
                    reg_write     = wait_done;
                    pc_en         = wait_done;
                end
                MEM_WR: begin
                    mem_addr_src = 1'b1;
                    mem_we       = 1'b1;
                    pc_en        = 1'b1;
                end
                BRANCH: begin
                    pc_en = 1'b1;
                    case (dec_cls)
                        CLS_BCOND: pc_src = bus.cond_true ? PC_SRC_DISP : PC_SRC_INC;
                        CLS_JCOND: pc_src = bus.cond_true ? PC_SRC_RTGT : PC_SRC_INC;
                        CLS_JAL: begin
                            reg_write     = 1'b1;
                            reg_write_src = RWS_PC1;
                            pc_src        = PC_SRC_RTGT;
                        end
                        default: pc_src = PC_SRC_INC;
                    endcase
                end
                NOP: pc_en = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.instr_en      = instr_en;
    assign bus.mem_addr_src  = mem_addr_src;
    assign bus.mem_we        = mem_we;
    assign bus.pc_en         = pc_en;
    assign bus.pc_src        = pc_src;
    assign bus.reg_write     = reg_write;
    assign bus.reg_write_src = reg_write_src;
    assign bus.alu_A_src     = alu_a_src;
    assign bus.alu_B_src     = alu_b_src;
    assign bus.alu_cont      = alu_cont;
    assign bus.psr_en        = psr_en;
    assign bus.state_dbg     = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction strobe/latency scoreboard against a spec-level model.
`timescale 1ns/1ps
module tb_multicycle_controller;
    import bananachine_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       cond_true = 1'b0;
    logic [3:0] op_code = 4'd0;
    logic [3:0] ext_op_code = 4'd0;
    logic       sel3 = 1'b0;
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    multicycle_controller_if #(.ALU_CONT_W(6)) if_a ();
    multicycle_controller_if #(.ALU_CONT_W(6)) if_b ();
    multicycle_controller_if #(.ALU_CONT_W(6)) if_c ();

    assign if_a.run = run;  assign if_a.op_code = op_code;  assign if_a.ext_op_code = ext_op_code;  assign if_a.cond_true = cond_true;
    assign if_b.run = run;  assign if_b.op_code = op_code;  assign if_b.ext_op_code = ext_op_code;  assign if_b.cond_true = cond_true;
    assign if_c.run = run;  assign if_c.op_code = op_code;  assign if_c.ext_op_code = ext_op_code;  assign if_c.cond_true = cond_true;

    multicycle_controller #(.MEM_LATENCY(1), .ALU_CONT_W(6), .EN_JAL(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    multicycle_controller #(.MEM_LATENCY(1), .ALU_CONT_W(6), .EN_JAL(0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    multicycle_controller #(.MEM_LATENCY(3), .ALU_CONT_W(6), .EN_JAL(1)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    // Observed outputs of the DUT currently under test (L=1 or L=3).
    logic       o_instr_en, o_mem_addr, o_mem_we, o_pc_en, o_reg_write, o_psr_en, o_alu_a, o_alu_b;
    logic [1:0] o_pc_src, o_rws;
    logic [5:0] o_alu;
    logic [3:0] o_state;
    always_comb begin
        if (sel3) begin
            o_instr_en = if_c.instr_en; o_mem_addr = if_c.mem_addr_src; o_mem_we = if_c.mem_we;
            o_pc_en = if_c.pc_en; o_reg_write = if_c.reg_write; o_psr_en = if_c.psr_en;
            o_alu_a = if_c.alu_A_src; o_alu_b = if_c.alu_B_src; o_pc_src = if_c.pc_src;
            o_rws = if_c.reg_write_src; o_alu = if_c.alu_cont; o_state = if_c.state_dbg;
        end else begin
            o_instr_en = if_a.instr_en; o_mem_addr = if_a.mem_addr_src; o_mem_we = if_a.mem_we;
            o_pc_en = if_a.pc_en; o_reg_write = if_a.reg_write; o_psr_en = if_a.psr_en;
            o_alu_a = if_a.alu_A_src; o_alu_b = if_a.alu_B_src; o_pc_src = if_a.pc_src;
            o_rws = if_a.reg_write_src; o_alu = if_a.alu_cont; o_state = if_a.state_dbg;
        end
    end

    typedef struct {
        int         lat;
        int         n_we;
        int         n_rw;
        int         n_psr;
        logic [1:0] pc_src;
        logic [1:0] rws;
        logic [5:0] alu;
        bit         is_alu;
        logic       b_imm;
    } exp_t;

    // Expected per-instruction behaviour straight from the instruction-set rules.
    function automatic exp_t model(input logic [3:0] op, input logic [3:0] ext, input logic cond,
                                   input int l, input bit jal);
        exp_t e;
        e.lat = l + 3; e.n_we = 0; e.n_rw = 0; e.n_psr = 0; e.pc_src = 2'b00;
        e.rws = 2'b00; e.alu = 6'd0; e.is_alu = 1'b0; e.b_imm = 1'b0;
        if (op == 4'd0) begin
            e.is_alu = 1'b1; e.alu = {2'b00, ext};
            e.n_rw = (ext == 4'd11) ? 0 : 1;
            e.n_psr = (ext == 4'd5 || ext == 4'd9 || ext == 4'd11) ? 1 : 0;
        end else if (op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd13}) begin
            e.is_alu = 1'b1; e.b_imm = 1'b1;
            e.alu = (op == 4'd13) ? 6'b111111 : {2'b01, op};
            e.n_rw = (op == 4'd11) ? 0 : 1;
            e.n_psr = (op == 4'd5 || op == 4'd9 || op == 4'd11) ? 1 : 0;
        end else if (op == 4'd4 && ext == 4'd0) begin
            e.lat = 2 * l + 3; e.n_rw = 1; e.rws = 2'b01;
        end else if (op == 4'd4 && ext == 4'd4) begin
            e.n_we = 1;
        end else if (op == 4'd4 && ext == 4'd12) begin
            e.pc_src = cond ? 2'b10 : 2'b00;
        end else if (op == 4'd4 && ext == 4'd8 && jal) begin
            e.n_rw = 1; e.rws = 2'b10; e.pc_src = 2'b10;
        end else if (op == 4'd12) begin
            e.pc_src = cond ? 2'b01 : 2'b00;
        end
        return e;
    endfunction

    // Wait (bounded) for the instruction-register load strobe; returns cycles taken, 0 on timeout.
    task automatic wait_fetch(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (o_instr_en) begin n = i; break; end
        end
    endtask

    // Load one instruction at the pending IR strobe and score it until the next IR strobe.
    task automatic do_instr(input logic [3:0] op, input logic [3:0] ext, input logic cond, input string tag);
        exp_t e, eb;
        int cyc, n_pc, n_we, n_rw, n_psr, b_pc, b_rw, b_we;
        logic [1:0] s_pc, s_rws;
        logic [5:0] s_alu;
        logic s_b, s_a;
        bit seen;
        e  = model(op, ext, cond, sel3 ? 3 : 1, 1'b1);
        eb = model(op, ext, cond, 1, 1'b0);
        @(posedge clk); #1;
        op_code = op; ext_op_code = ext; cond_true = cond;
        cyc = 0; n_pc = 0; n_we = 0; n_rw = 0; n_psr = 0; b_pc = 0; b_rw = 0; b_we = 0;
        s_pc = 2'b11; s_rws = 2'b11; s_alu = 6'bxxxxxx; s_b = 1'bx; s_a = 1'bx; seen = 1'b0;
        while (cyc < 40 && !seen) begin
            @(negedge clk);
            cyc++;
            if (o_pc_en) begin n_pc++; s_pc = o_pc_src; s_alu = o_alu; s_b = o_alu_b; s_a = o_alu_a; end
            if (o_reg_write) begin n_rw++; s_rws = o_rws; end
            n_we  += int'(o_mem_we);
            n_psr += int'(o_psr_en);
            if (!sel3) begin
                b_pc += int'(if_b.pc_en); b_rw += int'(if_b.reg_write); b_we += int'(if_b.mem_we);
            end
            seen = o_instr_en;
        end
        $display("txn %s L=%0d op=%b ext=%b cond=%b cycles=%0d pc_en=%0d reg_write=%0d mem_we=%0d psr_en=%0d",
                 tag, sel3 ? 3 : 1, op, ext, cond, cyc, n_pc, n_rw, n_we, n_psr);
        checks++; if (!seen || cyc !== e.lat) $display("FAIL %s latency: got %0d want %0d", tag, cyc, e.lat); else passed++;
        checks++; if (n_pc !== 1) $display("FAIL %s pc_en_count: got %0d want 1", tag, n_pc); else passed++;
        checks++; if (n_we !== e.n_we) $display("FAIL %s mem_we_count: got %0d want %0d", tag, n_we, e.n_we); else passed++;
        checks++; if (n_rw !== e.n_rw) $display("FAIL %s reg_write_count: got %0d want %0d", tag, n_rw, e.n_rw); else passed++;
        checks++; if (n_psr !== e.n_psr) $display("FAIL %s psr_en_count: got %0d want %0d", tag, n_psr, e.n_psr); else passed++;
        checks++; if (s_pc !== e.pc_src) $display("FAIL %s pc_src: got %b want %b", tag, s_pc, e.pc_src); else passed++;
        if (e.n_rw > 0) begin
            checks++; if (s_rws !== e.rws) $display("FAIL %s reg_write_src: got %b want %b", tag, s_rws, e.rws); else passed++;
        end
        if (e.is_alu) begin
            checks++; if (s_alu !== e.alu) $display("FAIL %s alu_cont: got %b want %b", tag, s_alu, e.alu); else passed++;
            checks++; if ({s_a, s_b} !== {1'b1, e.b_imm}) $display("FAIL %s alu_src: got %b want %b", tag, {s_a, s_b}, {1'b1, e.b_imm}); else passed++;
        end
        if (!sel3) begin
            checks++; if (b_pc !== 1) $display("FAIL %s nojal_pc_en: got %0d want 1", tag, b_pc); else passed++;
            checks++; if (b_rw !== eb.n_rw) $display("FAIL %s nojal_reg_write: got %0d want %0d", tag, b_rw, eb.n_rw); else passed++;
            checks++; if (b_we !== eb.n_we) $display("FAIL %s nojal_mem_we: got %0d want %0d", tag, b_we, eb.n_we); else passed++;
        end
    endtask

    task automatic rand_instr(input string tag);
        logic [3:0] op, ext;
        int k;
        op = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) op = 4'd4;
        k = $urandom_range(0, 4);
        ext = (op == 4'd4 && k < 4) ? 4'(k * 4) : 4'($urandom_range(0, 15));
        do_instr(op, ext, 1'($urandom_range(0, 1)), tag);
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; run = 1'b1; op_code = 4'd4; ext_op_code = 4'd4; cond_true = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({o_instr_en, o_mem_addr, o_mem_we, o_pc_en, o_pc_src, o_reg_write, o_rws, o_alu_a, o_alu_b, o_alu, o_psr_en, o_state} !== 24'd0)
                $display("FAIL reset_outputs: got %b want all zero",
                         {o_instr_en, o_mem_addr, o_mem_we, o_pc_en, o_pc_src, o_reg_write, o_rws, o_alu_a, o_alu_b, o_alu, o_psr_en, o_state});
            else passed++;
        end
        @(posedge clk); #1; reset = 1'b0; run = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({o_state, o_instr_en, o_pc_en} !== 6'd0) $display("FAIL idle_hold: got state=%0d instr_en=%b pc_en=%b want 0/0/0", o_state, o_instr_en, o_pc_en);
            else passed++;
        end
        @(posedge clk); #1; run = 1'b1;
        wait_fetch(n);
        checks++; if (n !== 3) $display("FAIL first_fetch_cycles: got %0d want 3", n); else passed++;
    endtask

    task automatic test_program();
        do_instr(4'b1101, 4'd3, 1'b0, "MOVI_R1_3");
        do_instr(4'b1101, 4'd2, 1'b0, "MOVI_R2_2");
        do_instr(4'b0000, 4'b0101, 1'b0, "ADD_R1_R2");
        do_instr(4'b0100, 4'b0100, 1'b0, "STOR");
        do_instr(4'b0100, 4'b0000, 1'b0, "LOAD");
        do_instr(4'b1100, 4'd0, 1'b1, "BCOND_T");
        do_instr(4'b1100, 4'd0, 1'b0, "BCOND_F");
        do_instr(4'b0100, 4'b1000, 1'b0, "JAL");
        do_instr(4'b0100, 4'b1100, 1'b1, "JCOND_T");
        do_instr(4'b0100, 4'b1100, 1'b0, "JCOND_F");
        do_instr(4'b0000, 4'b1011, 1'b0, "CMP");
        do_instr(4'b1011, 4'd7, 1'b0, "CMPI");
        do_instr(4'b0111, 4'd0, 1'b0, "NOP_OP");
    endtask

    task automatic test_random(input int count);
        for (int i = 0; i < count; i++) rand_instr("RAND");
    endtask

    // Drop run during an ADD: it must finish, then the FSM parks in IDLE with no strobes.
    task automatic test_halt();
        int n_pc, n_rw, n_ie, late;
        bit done;
        @(posedge clk); #1;
        op_code = 4'b0000; ext_op_code = 4'b0101; cond_true = 1'b0; run = 1'b0;
        n_pc = 0; n_rw = 0; n_ie = 0; late = 0; done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done && (o_pc_en || o_reg_write || o_mem_we || o_instr_en || o_psr_en || o_mem_addr)) late++;
            if (o_pc_en) begin n_pc++; done = 1'b1; end
            n_rw += int'(o_reg_write);
            n_ie += int'(o_instr_en);
        end
        $display("txn HALT_ADD pc_en=%0d reg_write=%0d instr_en=%0d state=%0d", n_pc, n_rw, n_ie, o_state);
        checks++; if (n_pc !== 1) $display("FAIL halt_pc_en: got %0d want 1", n_pc); else passed++;
        checks++; if (n_rw !== 1) $display("FAIL halt_reg_write: got %0d want 1", n_rw); else passed++;
        checks++; if (n_ie !== 0) $display("FAIL halt_instr_en: got %0d want 0", n_ie); else passed++;
        checks++; if (late !== 0) $display("FAIL halt_idle_strobes: got %0d want 0", late); else passed++;
        checks++; if (o_state !== 4'd0) $display("FAIL halt_state: got %0d want 0", o_state); else passed++;
    endtask

    // Reset during the write-back cycle of a LOAD must suppress its strobes.
    task automatic test_reset_mid_load();
        int n;
        run = 1'b1;
        wait_fetch(n);
        checks++; if (n == 0) $display("FAIL midload_fetch_timeout: got none want instr_en"); else passed++;
        @(posedge clk); #1; op_code = 4'b0100; ext_op_code = 4'b0000; run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({o_mem_addr, o_reg_write, o_pc_en} !== 3'b100) $display("FAIL midload_rd1: got %b want 100", {o_mem_addr, o_reg_write, o_pc_en}); else passed++;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        checks++; if ({o_reg_write, o_pc_en} !== 2'b00) $display("FAIL midload_strobes: got %b want 00", {o_reg_write, o_pc_en}); else passed++;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        $display("txn RESET_IN_LOAD state=%0d pc_en=%b reg_write=%b", o_state, o_pc_en, o_reg_write);
        checks++; if (o_state !== 4'd0) $display("FAIL midload_state: got %0d want 0", o_state); else passed++;
        checks++; if ({o_reg_write, o_pc_en, o_instr_en} !== 3'b000) $display("FAIL midload_after: got %b want 000", {o_reg_write, o_pc_en, o_instr_en}); else passed++;
    endtask

    task automatic test_latency3();
        int n;
        sel3 = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0; run = 1'b1;
        wait_fetch(n);
        checks++; if (n !== 5) $display("FAIL l3_first_fetch_cycles: got %0d want 5", n); else passed++;
        do_instr(4'b0000, 4'b0101, 1'b0, "L3_ADD");
        do_instr(4'b0100, 4'b0000, 1'b0, "L3_LOAD");
        do_instr(4'b0100, 4'b0100, 1'b0, "L3_STOR");
        do_instr(4'b1101, 4'd9, 1'b0, "L3_MOVI");
        do_instr(4'b1100, 4'd0, 1'b1, "L3_BCOND");
        do_instr(4'b0100, 4'b1000, 1'b1, "L3_JAL");
        for (int i = 0; i < 10; i++) rand_instr("L3_RAND");
    endtask

    initial begin
        test_reset();
        test_program();
        test_random(40);
        test_halt();
        test_reset_mid_load();
        test_latency3();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule
